// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with clear sweep, dual write ports and optional bypass
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    parameter int unsigned INIT_IDX = 2,
    parameter int unsigned INIT_VAL = 1020,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic                wa_en,
    input  logic                wa_hold,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic                busy
);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic [XLEN-1:0]   mem_q [DEPTH];
    logic              we_a, we_b;

    always_ff @(posedge clk) begin
        if (!Rst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // The sweep counter wraps naturally to 0 on the final clear cycle.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == S_CLEAR) begin
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(DEPTH - 1)) begin
                state_d = S_READY;
            end
        end
    end

    always_comb begin
        busy = (state_q == S_CLEAR);
    end

    assign we_a = !busy && wa_en && !wa_hold && !(ZERO_REG && (wa_addr == '0));
    assign we_b = !busy && wb_en && !(ZERO_REG && (wb_addr == '0));

    // Port B is assigned last so it overrides port A on an address collision.
    always_ff @(posedge clk) begin
        if (Rst) begin
            if (busy) begin
                mem_q[clr_idx_q] <= (clr_idx_q == AW'(INIT_IDX)) ? XLEN'(INIT_VAL) : '0;
            end else begin
                if (we_a) begin
                    mem_q[wa_addr] <= wa_data;
                end
                if (we_b) begin
                    mem_q[wb_addr] <= wb_data;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdv;

        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            rdv = mem_q[ra];
            if (BYPASS) begin
                if (we_b && (wb_addr == ra)) begin
                    rdv = wb_data;
                end else if (we_a && (wa_addr == ra)) begin
                    rdv = wa_data;
                end
            end
            if (busy || (ZERO_REG && (ra == '0))) begin
                rdv = '0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = rdv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized check of three regfile_mp configurations against a behavioural model
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v;
    logic        wa_en_v   [3];
    logic        wa_hold_v [3];
    logic        wb_en_v   [3];
    logic [4:0]  wa_addr_v [3];
    logic [4:0]  wb_addr_v [3];
    logic [31:0] wa_data_v [3];
    logic [31:0] wb_data_v [3];
    logic [4:0]  ra_v      [3][4];

    logic [9:0]   rd_addr0, rd_addr1;
    logic [15:0]  rd_addr2;
    logic [63:0]  rd_data0, rd_data1;
    logic [127:0] rd_data2;
    logic         busy0, busy1, busy2;

    assign rd_addr0 = {ra_v[0][1], ra_v[0][0]};
    assign rd_addr1 = {ra_v[1][1], ra_v[1][0]};
    assign rd_addr2 = {ra_v[2][3][3:0], ra_v[2][2][3:0], ra_v[2][1][3:0], ra_v[2][0][3:0]};

    regfile_mp dut0 (
        .clk(clk), .Rst(rst_v),
        .wa_en(wa_en_v[0]), .wa_hold(wa_hold_v[0]), .wa_addr(wa_addr_v[0]), .wa_data(wa_data_v[0]),
        .wb_en(wb_en_v[0]), .wb_addr(wb_addr_v[0]), .wb_data(wb_data_v[0]),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .busy(busy0)
    );

    regfile_mp #(.ZERO_REG(1'b0)) dut1 (
        .clk(clk), .Rst(rst_v),
        .wa_en(wa_en_v[1]), .wa_hold(wa_hold_v[1]), .wa_addr(wa_addr_v[1]), .wa_data(wa_data_v[1]),
        .wb_en(wb_en_v[1]), .wb_addr(wb_addr_v[1]), .wb_data(wb_data_v[1]),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .busy(busy1)
    );

    regfile_mp #(.DEPTH(16), .NRD(4), .BYPASS(1'b0)) dut2 (
        .clk(clk), .Rst(rst_v),
        .wa_en(wa_en_v[2]), .wa_hold(wa_hold_v[2]), .wa_addr(wa_addr_v[2][3:0]), .wa_data(wa_data_v[2]),
        .wb_en(wb_en_v[2]), .wb_addr(wb_addr_v[2][3:0]), .wb_data(wb_data_v[2]),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2)
    );

    int unsigned dep [3] = '{32, 32, 16};
    bit          zr  [3] = '{1'b1, 1'b0, 1'b1};
    bit          byp [3] = '{1'b1, 1'b1, 1'b0};
    int unsigned nrd [3] = '{2, 2, 4};

    // Model: contents plus number of sweep cycles still outstanding (0 = ready).
    logic [31:0] m_mem  [3][32];
    int          m_left [3];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit m_we_a(int i);
        return m_left[i] == 0 && wa_en_v[i] && !wa_hold_v[i] && !(zr[i] && wa_addr_v[i] == 5'd0);
    endfunction

    function automatic bit m_we_b(int i);
        return m_left[i] == 0 && wb_en_v[i] && !(zr[i] && wb_addr_v[i] == 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(int i, int k);
        logic [4:0] a;
        a = ra_v[i][k];
        if (m_left[i] > 0) return 32'd0;
        if (zr[i] && a == 5'd0) return 32'd0;
        if (byp[i]) begin
            if (m_we_b(i) && wb_addr_v[i] == a) return wb_data_v[i];
            if (m_we_a(i) && wa_addr_v[i] == a) return wa_data_v[i];
        end
        return m_mem[i][a];
    endfunction

    function automatic logic [31:0] got_rd(int i, int k);
        case (i)
            0:       return rd_data0[k*32 +: 32];
            1:       return rd_data1[k*32 +: 32];
            default: return rd_data2[k*32 +: 32];
        endcase
    endfunction

    function automatic logic got_busy(int i);
        case (i)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit wa, wb;
            wa = m_we_a(i);
            wb = m_we_b(i);
            if (!rst_v) begin
                m_left[i] = dep[i];
            end else if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    for (int j = 0; j < 32; j++) m_mem[i][j] = 32'd0;
                    m_mem[i][2] = 32'd1020;
                end
            end else begin
                if (wa) m_mem[i][wa_addr_v[i]] = wa_data_v[i];
                if (wb) m_mem[i][wb_addr_v[i]] = wb_data_v[i];
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy%0d", i), {31'd0, got_busy(i)}, {31'd0, m_left[i] > 0});
            for (int k = 0; k < int'(nrd[i]); k++)
                check($sformatf("rd%0d_p%0d_x%0d", i, k, ra_v[i][k]), got_rd(i, k), exp_rd(i, k));
        end
    endtask

    task automatic step();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            wa_en_v[i] = 1'b0; wa_hold_v[i] = 1'b0; wb_en_v[i] = 1'b0;
            wa_addr_v[i] = '0; wb_addr_v[i] = '0; wa_data_v[i] = '0; wb_data_v[i] = '0;
        end
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            step();
            cnt++;
        end
        check(tag, cnt, 32);
    endtask

    initial begin
        rst_v = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            m_left[i] = 999;
            for (int k = 0; k < 4; k++) ra_v[i][k] = '0;
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst_v = 1'b1;
        wa_en_v[0] = 1'b1; wa_addr_v[0] = 5'd9; wa_data_v[0] = 32'h1111;
        wait_ready("sweep_len");
        idle();

        ra_v[0][0] = 5'd2; ra_v[0][1] = 5'd5;
        #1 check("x2_init", rd_data0[31:0], 32'd1020);
        check("x5_init", rd_data0[63:32], 32'd0);
        check("x9_lost", m_mem[0][9], 32'd0);
        ra_v[0][1] = 5'd0;
        #1 check("x0_init", rd_data0[63:32], 32'd0);
        step();

        wa_en_v[0] = 1'b1; wa_addr_v[0] = 5'd5; wa_data_v[0] = 32'hDEAD;
        wb_en_v[0] = 1'b1; wb_addr_v[0] = 5'd5; wb_data_v[0] = 32'hBEEF;
        ra_v[0][0] = 5'd5;
        #1 check("collide_byp", rd_data0[31:0], 32'hBEEF);
        step();
        idle();
        #1 check("collide_stored", rd_data0[31:0], 32'hBEEF);
        step();

        wa_en_v[0] = 1'b1; wa_hold_v[0] = 1'b1; wa_addr_v[0] = 5'd7; wa_data_v[0] = 32'h1234;
        ra_v[0][1] = 5'd7;
        #1 check("hold_byp", rd_data0[63:32], 32'd0);
        step();
        #1 check("hold_stored", rd_data0[63:32], 32'd0);
        wa_hold_v[0] = 1'b0;
        step();
        idle();
        #1 check("nohold_stored", rd_data0[63:32], 32'h1234);
        step();

        for (int i = 0; i < 2; i++) begin
            wa_en_v[i] = 1'b1; wa_addr_v[i] = 5'd0; wa_data_v[i] = 32'hFFFF;
            wb_en_v[i] = 1'b1; wb_addr_v[i] = 5'd0; wb_data_v[i] = 32'hFFFF;
            ra_v[i][0] = 5'd0;
        end
        #1 check("x0_zero_byp", rd_data0[31:0], 32'd0);
        check("x0_fp_byp", rd_data1[31:0], 32'hFFFF);
        step();
        idle();
        #1 check("x0_zero_stored", rd_data0[31:0], 32'd0);
        check("x0_fp_stored", rd_data1[31:0], 32'hFFFF);
        step();

        wa_en_v[2] = 1'b1; wa_addr_v[2] = 5'd3; wa_data_v[2] = 32'h77;
        for (int k = 0; k < 4; k++) ra_v[2][k] = 5'd3;
        #1 for (int k = 0; k < 4; k++) check($sformatf("nobyp_old_p%0d", k), rd_data2[k*32 +: 32], 32'd0);
        step();
        idle();
        #1 for (int k = 0; k < 4; k++) check($sformatf("nobyp_new_p%0d", k), rd_data2[k*32 +: 32], 32'h77);
        step();

        for (int c = 0; c < 400; c++) begin
            rst_v = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 3; i++) begin
                wa_en_v[i]   = $urandom_range(0, 1);
                wa_hold_v[i] = ($urandom_range(0, 3) == 0);
                wa_addr_v[i] = 5'($urandom_range(0, dep[i] - 1));
                wa_data_v[i] = $urandom;
                wb_en_v[i]   = $urandom_range(0, 1);
                wb_addr_v[i] = ($urandom_range(0, 3) == 0) ? wa_addr_v[i] : 5'($urandom_range(0, dep[i] - 1));
                wb_data_v[i] = $urandom;
                for (int k = 0; k < 4; k++)
                    ra_v[i][k] = ($urandom_range(0, 2) == 0) ? wa_addr_v[i] : 5'($urandom_range(0, dep[i] - 1));
            end
            step();
        end
        rst_v = 1'b1;
        idle();
        for (int c = 0; c < 40; c++) step();

        wa_en_v[0] = 1'b1; wa_addr_v[0] = 5'd9; wa_data_v[0] = 32'h55;
        step();
        idle();
        ra_v[0][0] = 5'd9;
        #1 check("x9_written", rd_data0[31:0], 32'h55);
        rst_v = 1'b0;
        step();
        rst_v = 1'b1;
        for (int c = 0; c < 10; c++) step();
        rst_v = 1'b0;
        step();
        rst_v = 1'b1;
        wait_ready("resweep_len");
        #1 check("x9_cleared", rd_data0[31:0], 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, 32: register width in bits.
REQ-002 Parameter DEPTH, 32: number of registers; power of two, >= 2; AW = log2(DEPTH).
REQ-003 Parameter NRD, 2: number of independent read ports, 1..4.
REQ-004 Parameter ZERO_REG, 1: 1 = register 0 hardwired to zero (integer file); 0 = register 0 is ordinary storage (FP file).
REQ-005 Parameter BYPASS, 1: 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.
REQ-006 Parameter INIT_IDX, 2: index preloaded at end of clear sweep.
REQ-007 Parameter INIT_VAL, 1020: value loaded into INIT_IDX.
REQ-008 Port clk  in  1  single clock; all state updates on rising edge.
REQ-009 Port Rst  in  1  reset, synchronous, active-low.
REQ-010 Port wa_en  in  1  write port A (pipeline writeback) enable.
REQ-011 Port wa_hold  in  1  memory hold; suppresses port A write when 1.
REQ-012 Port wa_addr  in  AW  port A address.
REQ-013 Port wa_data  in  XLEN  port A data.
REQ-014 Port wb_en  in  1  write port B (coprocessor/accelerator) enable.
REQ-015 Port wb_addr  in  AW  port B address.
REQ-016 Port wb_data  in  XLEN  port B data.
REQ-017 Port rd_addr  in  NRD*AW  packed read addresses; port k at bits [k*AW +: AW].
REQ-018 Port rd_data  out  NRD*XLEN  packed read data, same packing.
REQ-019 Port busy  out  1  clear sweep in progress.

Function
REQ-020 States: CLEAR, READY; 2-bit-or-less state register plus AW-bit sweep counter clr_idx.
REQ-021 Rst=0 at a rising edge: state<=CLEAR, clr_idx<=0, regardless of current state (reset mid-sweep restarts at 0).
REQ-022 CLEAR, Rst=1: each cycle write reg[clr_idx] <= (clr_idx==INIT_IDX ? INIT_VAL : 0), clr_idx++; sweep takes exactly DEPTH cycles.
REQ-023 CLEAR with clr_idx==DEPTH-1: state<=READY next edge; counter wraps to 0.
REQ-024 busy = 1 in CLEAR, 0 in READY; combinational from state.
REQ-025 In CLEAR: both write ports ignored, all rd_data = 0.
REQ-026 READY: port A effective write weA = wa_en & ~wa_hold & ~(ZERO_REG & wa_addr==0).
REQ-027 READY: port B effective write weB = wb_en & ~(ZERO_REG & wb_addr==0).
REQ-028 Writes commit at rising edge; weA and weB to different addresses both commit same cycle.
REQ-029 weA and weB to same address: port B data wins; port A discarded.
REQ-030 Reads combinational, zero-latency, per port independent; any number of ports may share an address.
REQ-031 ZERO_REG=1 and rd_addr_k==0: rd_data_k = 0 always.
REQ-032 BYPASS=1: if weB and wb_addr==rd_addr_k, rd_data_k = wb_data; else if weA and wa_addr==rd_addr_k, rd_data_k = wa_data; else stored value.
REQ-033 BYPASS=0: rd_data_k = stored value; new data visible cycle after commit.
REQ-034 INIT_IDX with ZERO_REG=1 and INIT_IDX==0: register 0 still reads 0 (hardwire dominates).
REQ-035 No storage bits outside DEPTH*XLEN array, state, clr_idx; no latches.

Reset
REQ-036 Rst synchronous, active-low; sampled only at rising clk.
REQ-037 After Rst deasserts, busy=1 for exactly DEPTH cycles; then contents all 0 except reg[INIT_IDX]=INIT_VAL.
REQ-038 Writes presented while Rst=0 or busy=1 are lost; no queuing.

Verification
REQ-039 Default params, Rst=0 one cycle then 1 -> busy=1 for 32 cycles, then read x2=1020, x5=0, x0=0.
REQ-040 READY, wa_en=1 wa_addr=5 wa_data=0xDEAD, wb_en=1 wb_addr=5 wb_data=0xBEEF -> rd same cycle (BYPASS=1) 0xBEEF; next cycle stored 0xBEEF.
REQ-041 READY, wa_en=1 wa_hold=1 addr=7 data=0x1234 -> x7 remains 0; same with wa_hold=0 -> x7=0x1234 next cycle.
REQ-042 ZERO_REG=1, write x0=0xFFFF on both ports -> rd x0=0; ZERO_REG=0 instance -> x0=0xFFFF next cycle.
REQ-043 Rst=0 asserted at sweep cycle 10 after x9 written 0x55 -> sweep restarts, busy=1 for full 32 cycles, x9=0 afterward.
REQ-044 NRD=4, DEPTH=16, BYPASS=0: four ports read x3 in cycle of write 0x77 -> all old value; next cycle all 0x77.
